// File: rtl/gap_state_detector_pkg.sv
// Shared definitions for the gap state detector: result codes, FSM
// state encoding, default thresholds and the delay classifier.
package gap_state_detector_pkg;

    // Default thresholds (mV and 65 MHz ADC clock cycles)
    localparam int V_BD_MV_DEF   = 1500;
    localparam int I_BD_MV_DEF   = 500;
    localparam int SHORT_CYC_DEF = 13;
    localparam int ARC_CYC_DEF   = 130;

    // Result codes reported on result_code
    localparam logic [1:0] GAP_OPEN   = 2'd0;
    localparam logic [1:0] GAP_NORMAL = 2'd1;
    localparam logic [1:0] GAP_ARC    = 2'd2;
    localparam logic [1:0] GAP_SHORT  = 2'd3;

    // Ceiling of the ignition delay counter
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Per-pulse classifier states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_BURN   = 2'd2,
        ST_REPORT = 2'd3
    } gap_state_e;

    // Map a breakdown delay onto SHORT / ARC / NORMAL
    function automatic logic [1:0] classify_delay(
        input logic [15:0] delay,
        input logic [15:0] short_lim,
        input logic [15:0] arc_lim
    );
        logic [1:0] code;
        if (delay < short_lim) begin
            code = GAP_SHORT;
        end else if (delay < arc_lim) begin
            code = GAP_ARC;
        end else begin
            code = GAP_NORMAL;
        end
        return code;
    endfunction

    // Counter increment that sticks at the ceiling
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        logic [15:0] next_value;
        if (value == CNT_MAX) begin
            next_value = value;
        end else begin
            next_value = value + 16'd1;
        end
        return next_value;
    endfunction

endpackage

// File: rtl/gap_state_detector_moving_avg4.sv
// 4-sample moving average of a signed 16-bit sample stream.
// Stage 1 captures the sample into a 4-deep tap line, stage 2 registers
// floor(sum/4); input-to-output latency is 2 cycles.
module moving_avg4 (
    input  logic               ad_clk,
    input  logic               rst_n,
    input  logic signed [15:0] din,
    output logic signed [15:0] dout
);

    logic signed [15:0] taps_q [4];
    logic        [17:0] sum_s;

    // Shift the newest sample into the tap line
    always_ff @(posedge ad_clk) begin
        if (!rst_n) begin
            taps_q[0] <= '0;
            taps_q[1] <= '0;
            taps_q[2] <= '0;
            taps_q[3] <= '0;
        end else begin
            taps_q[0] <= din;
            taps_q[1] <= taps_q[0];
            taps_q[2] <= taps_q[1];
            taps_q[3] <= taps_q[2];
        end
    end

    // 18-bit sum of the sign-extended taps; four 16-bit values cannot overflow it
    always_comb begin
        sum_s = {{2{taps_q[0][15]}}, taps_q[0]}
              + {{2{taps_q[1][15]}}, taps_q[1]}
              + {{2{taps_q[2][15]}}, taps_q[2]}
              + {{2{taps_q[3][15]}}, taps_q[3]};
    end

    // Dropping the two LSBs of the two's-complement sum is an arithmetic
    // shift right by 2, i.e. floor division by 4 for negative sums too
    always_ff @(posedge ad_clk) begin
        if (!rst_n) begin
            dout <= '0;
        end else begin
            dout <= sum_s[17:2];
        end
    end

endmodule

// File: rtl/gap_state_detector.sv
// Per-pulse EDM gap classifier. Filters board current and gap voltage,
// watches the delayed pulse gate, and at the end of every discharge pulse
// reports OPEN / NORMAL / ARC / SHORT together with the ignition delay.
//
// Result interface: result_valid is a single-cycle strobe with no
// back-pressure; result_code and ign_delay are valid in that cycle and
// hold their value until the next strobe. The consumer must sample on
// the strobe cycle.
module gap_state_detector
    import gap_state_detector_pkg::*;
#(
    parameter int V_BD_MV   = V_BD_MV_DEF,
    parameter int I_BD_MV   = I_BD_MV_DEF,
    parameter int SHORT_CYC = SHORT_CYC_DEF,
    parameter int ARC_CYC   = ARC_CYC_DEF     // must exceed SHORT_CYC
) (
    input  logic               ad_clk,
    input  logic               rst_n,
    input  logic signed [15:0] volt_ch1,
    input  logic signed [15:0] volt_ch2,
    input  logic               pulse_on,
    output logic signed [15:0] curr_avg,
    output logic signed [15:0] volt_avg,
    output logic               result_valid,
    output logic        [1:0]  result_code,
    output logic        [15:0] ign_delay
);

    localparam logic signed [15:0] V_BD_LIM  = 16'(V_BD_MV);
    localparam logic signed [15:0] I_BD_LIM  = 16'(I_BD_MV);
    localparam logic        [15:0] SHORT_LIM = 16'(SHORT_CYC);
    localparam logic        [15:0] ARC_LIM   = 16'(ARC_CYC);

    // Pulse gate pipeline
    logic pulse_p1_q;
    logic pulse_d_q;
    logic pulse_d_prev_q;
    logic armed_q;
    logic pulse_rise;
    logic pulse_fall;

    // Breakdown detection
    logic bd;

    // Classifier state (state_q is the observable FSM state)
    gap_state_e  state_q;
    gap_state_e  state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [15:0] delay_q;
    logic [15:0] delay_d;
    logic [1:0]  code_q;
    logic [1:0]  code_d;
    logic [15:0] ign_q;
    logic [15:0] ign_d;

    moving_avg4 u_curr_avg (
        .ad_clk (ad_clk),
        .rst_n  (rst_n),
        .din    (volt_ch1),
        .dout   (curr_avg)
    );

    moving_avg4 u_volt_avg (
        .ad_clk (ad_clk),
        .rst_n  (rst_n),
        .din    (volt_ch2),
        .dout   (volt_avg)
    );

    // Delay pulse_on by two cycles to line up with the averages. armed_q
    // stays low after reset until pulse_on has been seen low, so a pulse
    // already running across reset never produces a rising edge.
    always_ff @(posedge ad_clk) begin
        if (!rst_n) begin
            armed_q        <= 1'b0;
            pulse_p1_q     <= 1'b0;
            pulse_d_q      <= 1'b0;
            pulse_d_prev_q <= 1'b0;
        end else begin
            armed_q        <= armed_q | ~pulse_on;
            pulse_p1_q     <= pulse_on & armed_q;
            pulse_d_q      <= pulse_p1_q;
            pulse_d_prev_q <= pulse_d_q;
        end
    end

    // Edge detect on the aligned gate and signed breakdown test
    always_comb begin
        pulse_rise = pulse_d_q & ~pulse_d_prev_q;
        pulse_fall = ~pulse_d_q & pulse_d_prev_q;
        bd         = (volt_avg < V_BD_LIM) && (curr_avg > I_BD_LIM);
    end

    // Classifier state and result registers
    always_ff @(posedge ad_clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            delay_q <= '0;
            code_q  <= GAP_OPEN;
            ign_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            delay_q <= delay_d;
            code_q  <= code_d;
            ign_q   <= ign_d;
        end
    end

    // Next-state logic: count from pulse start, latch the breakdown delay,
    // and load the result registers on the way into REPORT
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        delay_d = delay_q;
        code_d  = code_q;
        ign_d   = ign_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pulse_rise) begin
                    state_d = ST_WAIT;
                    cnt_d   = 16'd1;
                end
            end

            ST_WAIT: begin
                cnt_d = sat_inc(cnt_q);
                if (bd) begin
                    // Breakdown beats a simultaneous end of pulse
                    delay_d = cnt_q;
                    if (pulse_fall) begin
                        state_d = ST_REPORT;
                        code_d  = classify_delay(cnt_q, SHORT_LIM, ARC_LIM);
                        ign_d   = cnt_q;
                    end else begin
                        state_d = ST_BURN;
                    end
                end else if (pulse_fall) begin
                    state_d = ST_REPORT;
                    code_d  = GAP_OPEN;
                    ign_d   = cnt_q;
                end
            end

            ST_BURN: begin
                if (pulse_fall) begin
                    state_d = ST_REPORT;
                    code_d  = classify_delay(delay_q, SHORT_LIM, ARC_LIM);
                    ign_d   = delay_q;
                end
            end

            ST_REPORT: begin
                // A pulse that starts right away must not be missed
                if (pulse_rise) begin
                    state_d = ST_WAIT;
                    cnt_d   = 16'd1;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign result_valid = (state_q == ST_REPORT);
    assign result_code  = code_q;
    assign ign_delay    = ign_q;

endmodule

// File: tb/tb_gap_state_detector.sv
// Directed bench for gap_state_detector: filter response, the four pulse
// classes, back-to-back pulses and reset in the middle of a pulse.
module tb_gap_state_detector;
    import gap_state_detector_pkg::*;

    // Clock / reset
    logic               ad_clk = 1'b0;
    logic               rst_n  = 1'b0;
    logic signed [15:0] volt_ch1 = '0;
    logic signed [15:0] volt_ch2 = '0;
    logic               pulse_on = 1'b0;
    logic signed [15:0] curr_avg;
    logic signed [15:0] volt_avg;
    logic               result_valid;
    logic        [1:0]  result_code;
    logic        [15:0] ign_delay;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    // Scoreboard: expected {code, delay} and what the monitor captured
    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];
    int          got_cyc_q[$];

    always #5 ad_clk = ~ad_clk;

    always @(posedge ad_clk) cyc <= cyc + 1;

    // Capture every strobe with the cycle it appeared in
    always @(negedge ad_clk) begin
        if (result_valid === 1'b1) begin
            got_q.push_back({result_code, ign_delay});
            got_cyc_q.push_back(cyc);
        end
    end

    gap_state_detector dut (
        .ad_clk       (ad_clk),
        .rst_n        (rst_n),
        .volt_ch1     (volt_ch1),
        .volt_ch2     (volt_ch2),
        .pulse_on     (pulse_on),
        .curr_avg     (curr_avg),
        .volt_avg     (volt_avg),
        .result_valid (result_valid),
        .result_code  (result_code),
        .ign_delay    (ign_delay)
    );

    // Driver tasks
    task automatic idle(input int n);
        repeat (n) @(negedge ad_clk);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        got_cyc_q.delete();
    endtask

    // Open-gap levels long enough to fill the filters
    task automatic settle();
        pulse_on = 1'b0;
        volt_ch2 = 16'sd3000;
        volt_ch1 = 16'sd0;
        idle(8);
    endtask

    // Drive a pulse of len cycles; at pulse cycle bd_at switch to the
    // breakdown levels. fall_cyc is the cycle count at the drop of pulse_on.
    task automatic run_pulse(input int len, input int bd_at,
                             input logic signed [15:0] bd_v,
                             input logic signed [15:0] bd_i,
                             output int fall_cyc);
        for (int i = 0; i < len; i++) begin
            @(negedge ad_clk);
            pulse_on = 1'b1;
            if (i == bd_at) begin
                volt_ch2 = bd_v;
                volt_ch1 = bd_i;
            end
        end
        @(negedge ad_clk);
        pulse_on = 1'b0;
        fall_cyc = cyc;
        volt_ch2 = 16'sd3000;
        volt_ch1 = 16'sd0;
    endtask

    // Wait (bounded) for n strobes, then a few more cycles to catch extras
    task automatic wait_strobes(input int n);
        int k;
        k = 0;
        while (got_q.size() < n && k < 40) begin
            @(negedge ad_clk);
            k++;
        end
        idle(6);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        vec_cnt++;
        if (result_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_valid: got %b, expected 0", result_valid);
        end
        vec_cnt++;
        if (result_code !== 2'd0 || ign_delay !== 16'd0) begin
            err_cnt++;
            $display("FAIL reset_result: got code %0d delay %0d, expected 0/0", result_code, ign_delay);
        end
        vec_cnt++;
        if (curr_avg !== 16'sd0 || volt_avg !== 16'sd0) begin
            err_cnt++;
            $display("FAIL reset_avg: got curr %0d volt %0d, expected 0/0", curr_avg, volt_avg);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_filter();
        logic signed [15:0] exp_avg[5];
        exp_avg = '{16'sd0, 16'sd1000, 16'sd2000, 16'sd3000, 16'sd4000};
        clear_sb();
        volt_ch2 = 16'sd0;
        volt_ch1 = 16'sd0;
        idle(5);
        vec_cnt++;
        if (volt_avg !== 16'sd0) begin
            err_cnt++;
            $display("FAIL filter_zero: got %0d, expected 0", volt_avg);
        end
        volt_ch2 = 16'sd4000;
        for (int j = 0; j < 5; j++) begin
            @(negedge ad_clk);
            vec_cnt++;
            if (volt_avg !== exp_avg[j]) begin
                err_cnt++;
                $display("FAIL filter_step+%0d: got %0d, expected %0d", j + 1, volt_avg, exp_avg[j]);
            end
        end
        // One sample of -2 must average to floor(-2/4) = -1
        volt_ch1 = -16'sd2;
        @(negedge ad_clk);
        volt_ch1 = 16'sd0;
        @(negedge ad_clk);
        vec_cnt++;
        if (curr_avg !== -16'sd1) begin
            err_cnt++;
            $display("FAIL filter_floor: got %0d, expected -1", curr_avg);
        end
        idle(3);
        vec_cnt++;
        if (got_q.size() !== 0) begin
            err_cnt++;
            $display("FAIL filter_no_strobe: got %0d strobes, expected 0", got_q.size());
        end
    endtask

    // One pulse, one expected result with the strobe 3 cycles after the fall
    task automatic test_single(input string name, input int len, input int bd_at,
                               input logic signed [15:0] bd_v,
                               input logic signed [15:0] bd_i,
                               input logic [1:0] exp_code,
                               input logic [15:0] exp_delay);
        int          fc;
        int          gc;
        logic [17:0] got;
        logic [17:0] exp;
        clear_sb();
        settle();
        exp_q.push_back({exp_code, exp_delay});
        run_pulse(len, bd_at, bd_v, bd_i, fc);
        wait_strobes(1);
        vec_cnt++;
        if (got_q.size() !== 1) begin
            err_cnt++;
            $display("FAIL %s_count: got %0d strobes, expected 1", name, got_q.size());
        end
        if (got_q.size() > 0) begin
            got = got_q.pop_front();
            gc  = got_cyc_q.pop_front();
            exp = exp_q.pop_front();
            vec_cnt++;
            if (got !== exp) begin
                err_cnt++;
                $display("FAIL %s_result: got code %0d delay %0d, expected code %0d delay %0d",
                         name, got[17:16], got[15:0], exp[17:16], exp[15:0]);
            end
            vec_cnt++;
            if (gc !== fc + 3) begin
                err_cnt++;
                $display("FAIL %s_timing: strobe at cycle %0d, expected %0d", name, gc, fc + 3);
            end
            vec_cnt++;
            if (result_valid !== 1'b0 || {result_code, ign_delay} !== exp) begin
                err_cnt++;
                $display("FAIL %s_hold: got valid %b code %0d delay %0d, expected 0/%0d/%0d",
                         name, result_valid, result_code, ign_delay, exp[17:16], exp[15:0]);
            end
        end
    endtask

    task automatic test_open();
        test_single("open", 200, -1, 16'sd0, 16'sd0, GAP_OPEN, 16'd200);
    endtask

    // New sample at pulse cycle s reaches bd on the third averaged sample: delay = s + 2
    task automatic test_normal();
        test_single("normal", 500, 300, 16'sd800, 16'sd2000, GAP_NORMAL, 16'd302);
    endtask

    task automatic test_short();
        test_single("short", 100, 0, 16'sd200, 16'sd3000, GAP_SHORT, 16'd2);
    endtask

    task automatic test_arc();
        test_single("arc", 100, 50, 16'sd800, 16'sd2000, GAP_ARC, 16'd52);
    endtask

    task automatic test_one_cycle();
        test_single("one_cycle", 1, -1, 16'sd0, 16'sd0, GAP_OPEN, 16'd1);
    endtask

    task automatic test_back_to_back();
        int          fc1;
        int          fc2;
        int          gc;
        logic [17:0] got;
        logic [17:0] exp;
        clear_sb();
        settle();
        exp_q.push_back({GAP_OPEN, 16'd100});
        exp_q.push_back({GAP_OPEN, 16'd100});
        run_pulse(100, -1, 16'sd0, 16'sd0, fc1);
        run_pulse(100, -1, 16'sd0, 16'sd0, fc2);
        wait_strobes(2);
        vec_cnt++;
        if (got_q.size() !== 2) begin
            err_cnt++;
            $display("FAIL b2b_count: got %0d strobes, expected 2", got_q.size());
        end
        for (int p = 0; p < 2; p++) begin
            if (got_q.size() > 0) begin
                got = got_q.pop_front();
                gc  = got_cyc_q.pop_front();
                exp = exp_q.pop_front();
                vec_cnt++;
                if (got !== exp) begin
                    err_cnt++;
                    $display("FAIL b2b_result%0d: got code %0d delay %0d, expected code %0d delay %0d",
                             p, got[17:16], got[15:0], exp[17:16], exp[15:0]);
                end
                vec_cnt++;
                if (gc !== ((p == 0) ? fc1 : fc2) + 3) begin
                    err_cnt++;
                    $display("FAIL b2b_timing%0d: strobe at cycle %0d, expected %0d",
                             p, gc, ((p == 0) ? fc1 : fc2) + 3);
                end
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        clear_sb();
        settle();
        for (int i = 0; i < 100; i++) begin
            @(negedge ad_clk);
            if (i == 51) begin
                vec_cnt++;
                if (result_valid !== 1'b0 || result_code !== 2'd0 || ign_delay !== 16'd0) begin
                    err_cnt++;
                    $display("FAIL midrst_result: got valid %b code %0d delay %0d, expected 0/0/0",
                             result_valid, result_code, ign_delay);
                end
                vec_cnt++;
                if (curr_avg !== 16'sd0 || volt_avg !== 16'sd0) begin
                    err_cnt++;
                    $display("FAIL midrst_avg: got curr %0d volt %0d, expected 0/0", curr_avg, volt_avg);
                end
            end
            pulse_on = 1'b1;
            if (i == 50) rst_n = 1'b0;
            if (i == 52) rst_n = 1'b1;
        end
        @(negedge ad_clk);
        pulse_on = 1'b0;
        idle(20);
        vec_cnt++;
        if (got_q.size() !== 0) begin
            err_cnt++;
            $display("FAIL midrst_discard: got %0d strobes, expected 0", got_q.size());
        end
        test_single("after_rst", 100, -1, 16'sd0, 16'sd0, GAP_OPEN, 16'd100);
    endtask

    initial begin
        test_reset();
        test_filter();
        test_open();
        test_normal();
        test_short();
        test_arc();
        test_one_cycle();
        test_back_to_back();
        test_reset_mid_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gap_state_detector.md
Name: gap_state_detector

Overview:
- Consumes the per-sample board current (ch1) and gap voltage (ch2), in signed mV, from the ADC conversion stage. Both are filtered with a 4-sample moving average.
- For every discharge pulse it classifies the gap as OPEN, NORMAL, ARC or SHORT and measures the ignition delay.
- Results feed the servo/pulse-control logic as one-cycle result strobes. Runs in the 65 MHz ADC clock domain.

Parameters:
- V_BD_MV, 1500, gap voltage (mV) below which breakdown is possible.
- I_BD_MV, 500, board current (mV) above which breakdown is confirmed.
- SHORT_CYC, 13, breakdown delay (cycles) below which the pulse is SHORT (~200 ns).
- ARC_CYC, 130, breakdown delay (cycles) below which the pulse is ARC (~2 us); must be > SHORT_CYC.

Ports:
- ad_clk  in  1  sample clock, 65 MHz
- rst_n  in  1  reset; synchronous, active-low
- volt_ch1  in  16  board current, signed mV, new sample every cycle
- volt_ch2  in  16  gap voltage, signed mV, new sample every cycle
- pulse_on  in  1  discharge pulse gate from the pulse generator, same clock domain
- curr_avg  out  16  filtered board current, signed mV
- volt_avg  out  16  filtered gap voltage, signed mV
- result_valid  out  1  one-cycle strobe at the end of each pulse
- result_code  out  2  0=OPEN 1=NORMAL 2=ARC 3=SHORT; valid with result_valid
- ign_delay  out  16  cycles from pulse start to breakdown (OPEN: pulse length); saturates at 16'hFFFF

Behaviour:
- Reset (rst_n low at a clock edge) clears all outputs, filter history, counters and the pulse_on pipeline. FSM returns to IDLE.
- Reset during a pulse discards that pulse; no result is emitted for it. A new pulse needs a fresh rising edge seen after reset.
- Filter (per channel):
  - Cycle 1: register the input into a 4-deep shift register.
  - Cycle 2: the 18-bit signed sum of the 4 taps, arithmetic-shifted right by 2 (floor), drives curr_avg/volt_avg.
  - Total latency from input to avg output is 2 cycles. Taps are zero after reset.
- pulse_on is delayed 2 cycles (pulse_d) so it aligns with the averages. Rising and falling edges are detected on pulse_d.
- Breakdown condition bd = (volt_avg < V_BD_MV) && (curr_avg > I_BD_MV), signed compare. Negative voltage counts as low.
- FSM:
  - IDLE: cnt=0. On pulse_d rise -> WAIT with cnt=1.
  - WAIT: cnt increments each cycle, saturating at 16'hFFFF.
    - If bd -> latch delay=cnt and go to BURN.
    - If pulse_d falls first -> REPORT with code OPEN and delay=cnt.
    - If bd and the fall occur in the same cycle, bd wins: latch delay=cnt and go straight to REPORT.
  - BURN: wait for pulse_d fall -> REPORT. Code is assigned from the latched delay:
    - delay < SHORT_CYC -> SHORT
    - else delay < ARC_CYC -> ARC
    - else NORMAL
  - REPORT: result_valid=1 for exactly one cycle with code and ign_delay, then -> IDLE.
    - If pulse_d rises in this cycle, go directly to WAIT with cnt=1 instead, so back-to-back pulses are not lost.
- Between strobes, result_code and ign_delay hold their last values. result_valid is 0 except in REPORT.
- The result strobe occurs 1 cycle after the pulse_d fall, i.e. 3 cycles after the pulse_on fall.
- A pulse_on high for only one cycle still yields a result: OPEN with delay 1, unless bd is true in that cycle.

Decomposition:
- Shared package holds:
  - result code constants (GAP_OPEN, GAP_NORMAL, GAP_ARC, GAP_SHORT)
  - FSM state encodings
  - default threshold constants
- One sub-module is natural: moving_avg4 (16-bit signed in, 16-bit signed out, 2-cycle latency), instantiated once per channel.

Test Plan:
- Filter check: ch2 steps 0 -> 4000 while pulse_on=0 -> volt_avg reads 0, then 1000/2000/3000/4000 on cycles +2..+5. No result_valid.
- OPEN: ch2=3000, ch1=0, pulse_on high 200 cycles -> one strobe, code=0, ign_delay=200.
- NORMAL: ch2=3000; pulse_on high; at cycle 300 of the pulse, ch2=800 and ch1=2000; pulse ends at cycle 500 -> code=1, ign_delay≈302 (within ±2 for filter fill).
- SHORT: ch2=200 and ch1=3000 throughout a 100-cycle pulse -> code=3, ign_delay ≤ 4. ARC: same stimulus with breakdown at pulse cycle 50 -> code=2.
- Back-to-back: pulse_on low for exactly 1 cycle between two 100-cycle OPEN pulses -> two strobes, both code=0, ign_delay=100.
- Reset mid-pulse: rst_n low for 2 cycles during WAIT -> no strobe for that pulse, outputs read 0, and the next complete pulse reports normally.
